aes_axis_cmd_master: RTL and testbench

AXI-Stream initiator that drives the AES accelerator's command interface and collects its result.
- Accepts one parallel request: command word plus 128-bit payload (key or plaintext).
- Serialises it into a 5-beat command packet on the master stream.
- Receives the 4-beat result packet on the slave stream and presents it as one 128-bit response.
- Used as the on-chip source/sink for the accelerator in self-test and in PL-side crypto users.

---
 rtl/aes_axis_cmd_master.sv | 181 ++++++++++++++++++
 tb/tb_aes_axis_cmd_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_axis_cmd_master.sv
// AXI-Stream command master for the AES accelerator: serialises {cmd, payload} and collects the result packet.
// Optional response watchdog: define AES_AXIS_CMD_TIMEOUT_EN.
module aes_axis_cmd_master #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int PAYLOAD_WORDS        = 4,
  parameter int RSP_WORDS            = 4,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                              axis_aclk,
  input  logic                              axis_aresetn,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [31:0]                       req_cmd,
  input  logic [127:0]                      req_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [127:0]                      rsp_data,
  output logic                              rsp_err,
  output logic                              rsp_timeout,
  output logic                              m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                              m00_axis_tlast,
  input  logic                              m00_axis_tready,
  input  logic                              s00_axis_tvalid,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                              s00_axis_tlast,
  output logic                              s00_axis_tready
);

  localparam int TXW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam int RXW = (RSP_WORDS > 1) ? $clog2(RSP_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, RECV, PRESENT} state_t;

  state_t           state_reg;
  logic [31:0]      tx_buf [PAYLOAD_WORDS];
  logic [31:0]      payload_words [PAYLOAD_WORDS];
  logic [31:0]      rsp_words [RSP_WORDS];
  logic [TXW-1:0]   tx_ptr_reg;
  logic [RXW-1:0]   rx_ptr_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;
  logic             m_tvalid_reg;
  logic             m_tlast_reg;
  logic [31:0]      m_tdata_reg;
  logic             s_tready_reg;
  logic             rx_fire;
  logic             rx_last_beat;

  // Payload is sent most-significant word first; result fills from the top down.
  for (genvar gi = 0; gi < PAYLOAD_WORDS; gi++) begin : g_payload
    assign payload_words[gi] = req_data[127-32*gi -: 32];
  end
  for (genvar gi = 0; gi < RSP_WORDS; gi++) begin : g_rsp
    assign rsp_data[127-32*gi -: 32] = rsp_words[gi];
  end

  assign rx_fire      = s00_axis_tvalid && s_tready_reg;
  assign rx_last_beat = (rx_ptr_reg == RXW'(RSP_WORDS-1));

  assign req_ready       = req_ready_reg;
  assign rsp_valid       = rsp_valid_reg;
  assign rsp_err         = rsp_err_reg;
  assign m00_axis_tvalid = m_tvalid_reg;
  assign m00_axis_tdata  = m_tdata_reg;
  assign m00_axis_tlast  = m_tlast_reg;
  assign m00_axis_tstrb  = '1;
  assign s00_axis_tready = s_tready_reg;

`ifdef AES_AXIS_CMD_TIMEOUT_EN
  logic [31:0] wd_cnt_reg;
  logic        rsp_timeout_reg;
  logic        wd_expire;
  assign wd_expire   = (wd_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = rsp_timeout_reg;
  logic unused_ok;
  assign unused_ok = &{1'b0, s00_axis_tstrb};
`else
  assign rsp_timeout = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, s00_axis_tstrb, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_reg     <= IDLE;
      tx_ptr_reg    <= '0;
      rx_ptr_reg    <= '0;
      req_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      m_tvalid_reg  <= 1'b0;
      m_tlast_reg   <= 1'b0;
      m_tdata_reg   <= '0;
      s_tready_reg  <= 1'b0;
      for (int i = 0; i < PAYLOAD_WORDS; i++) tx_buf[i] <= '0;
      for (int i = 0; i < RSP_WORDS; i++) rsp_words[i] <= '0;
`ifdef AES_AXIS_CMD_TIMEOUT_EN
      wd_cnt_reg      <= '0;
      rsp_timeout_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (req_valid && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            for (int i = 0; i < PAYLOAD_WORDS; i++) tx_buf[i] <= payload_words[i];
            // Clearing the result here makes unreceived words read as zero on error/timeout.
            for (int i = 0; i < RSP_WORDS; i++) rsp_words[i] <= '0;
            m_tvalid_reg <= 1'b1;
            m_tdata_reg  <= req_cmd;
            m_tlast_reg  <= 1'b0;
            tx_ptr_reg   <= '0;
            rsp_err_reg  <= 1'b0;
`ifdef AES_AXIS_CMD_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
`endif
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (m_tvalid_reg && m00_axis_tready) begin
            if (m_tlast_reg) begin
              m_tvalid_reg <= 1'b0;
              m_tlast_reg  <= 1'b0;
              m_tdata_reg  <= '0;
              s_tready_reg <= 1'b1;
              rx_ptr_reg   <= '0;
`ifdef AES_AXIS_CMD_TIMEOUT_EN
              wd_cnt_reg <= '0;
`endif
              state_reg <= RECV;
            end else begin
              m_tdata_reg <= tx_buf[tx_ptr_reg];
              m_tlast_reg <= (tx_ptr_reg == TXW'(PAYLOAD_WORDS-1));
              tx_ptr_reg  <= tx_ptr_reg + TXW'(1);
            end
          end
        end
        RECV: begin
          if (rx_fire) rsp_words[rx_ptr_reg] <= s00_axis_tdata;
`ifdef AES_AXIS_CMD_TIMEOUT_EN
          wd_cnt_reg <= wd_cnt_reg + 32'd1;
          if (wd_expire) begin
            rsp_timeout_reg <= 1'b1;
            rsp_err_reg     <= 1'b1;
            s_tready_reg    <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= PRESENT;
          end else
`endif
          if (rx_fire) begin
            if (s00_axis_tlast || rx_last_beat) begin
              // Good framing needs tlast exactly on the final expected beat.
              rsp_err_reg   <= !(s00_axis_tlast && rx_last_beat);
              s_tready_reg  <= 1'b0;
              rsp_valid_reg <= 1'b1;
              state_reg     <= PRESENT;
            end else begin
              rx_ptr_reg <= rx_ptr_reg + RXW'(1);
            end
          end
        end
        PRESENT: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            req_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_axis_cmd_master.sv
// Scoreboard bench for aes_axis_cmd_master: directed requests/replies, a monitor checks every beat and response.
module tb_aes_axis_cmd_master;

  localparam logic [31:0] CMD_SET_KEY = 32'h0000_0001;
  localparam logic [31:0] CMD_ENCRYPT = 32'h0000_0002;
`ifdef AES_AXIS_CMD_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic         axis_aclk = 1'b0;
  logic         axis_aresetn = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_cmd = '0;
  logic [127:0] req_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [127:0] rsp_data;
  logic         rsp_err;
  logic         rsp_timeout;
  logic         m00_axis_tvalid;
  logic [31:0]  m00_axis_tdata;
  logic [3:0]   m00_axis_tstrb;
  logic         m00_axis_tlast;
  logic         m00_axis_tready = 1'b1;
  logic         s00_axis_tvalid = 1'b0;
  logic [31:0]  s00_axis_tdata = '0;
  logic [3:0]   s00_axis_tstrb = 4'hf;
  logic         s00_axis_tlast = 1'b0;
  logic         s00_axis_tready;

  aes_axis_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .axis_aclk(axis_aclk), .axis_aresetn(axis_aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
    .m00_axis_tstrb(m00_axis_tstrb), .m00_axis_tlast(m00_axis_tlast),
    .m00_axis_tready(m00_axis_tready),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tdata(s00_axis_tdata),
    .s00_axis_tstrb(s00_axis_tstrb), .s00_axis_tlast(s00_axis_tlast),
    .s00_axis_tready(s00_axis_tready)
  );

  always #5 axis_aclk = ~axis_aclk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  logic [32:0]  tx_q[$];    // {tlast, tdata}
  logic [129:0] rsp_q[$];   // {err, timeout, data}
  bit toggle_en = 0;
  bit consec_check = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic bound_fail(input string name);
    checks++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  initial forever begin
    @(posedge axis_aclk);
    cyc++;
    #1;
    if (toggle_en) m00_axis_tready = ~m00_axis_tready;
  end

  // Monitor: compares every presented beat/response against the scoreboard queues.
  initial begin
    bit in_pkt = 0;
    bit post_rsp = 0;
    int beat_idx = 0;
    int req_hs = 0;
    int last_hs = 0;
    logic [32:0]  et;
    logic [129:0] er;
    forever begin
      @(negedge axis_aclk);
      if (!axis_aresetn) begin
        in_pkt = 0; post_rsp = 0; beat_idx = 0;
        continue;
      end
      if (post_rsp) begin
        chk("rsp_valid_drop", {127'd0, rsp_valid}, 128'd0);
        chk("req_ready_after_rsp", {127'd0, req_ready}, 128'd1);
        post_rsp = 0;
      end
      if (req_valid && req_ready) req_hs = cyc;
      if (in_pkt) chk("tvalid_held", {127'd0, m00_axis_tvalid}, 128'd1);
      if (m00_axis_tvalid) begin
        if (tx_q.size() == 0) bound_fail("tx_unexpected_beat");
        else begin
          et = tx_q[0];
          chk("tx_data", {96'd0, m00_axis_tdata}, {96'd0, et[31:0]});
          chk("tx_last", {127'd0, m00_axis_tlast}, {127'd0, et[32]});
          if (m00_axis_tready) begin
            if (consec_check)
              chk("tx_cycle", 128'(cyc), 128'((beat_idx == 0) ? req_hs + 1 : last_hs + 1));
            $display("tx beat %0d data=%h last=%0b", beat_idx, m00_axis_tdata, m00_axis_tlast);
            last_hs = cyc;
            void'(tx_q.pop_front());
            in_pkt = !et[32];
            beat_idx = et[32] ? 0 : beat_idx + 1;
          end
        end
      end
      if (rsp_valid) begin
        chk("req_ready_in_present", {127'd0, req_ready}, 128'd0);
        chk("s_tready_in_present", {127'd0, s00_axis_tready}, 128'd0);
        if (rsp_q.size() == 0) bound_fail("rsp_unexpected");
        else begin
          er = rsp_q[0];
          chk("rsp_data", rsp_data, er[127:0]);
          chk("rsp_err", {127'd0, rsp_err}, {127'd0, er[129]});
          chk("rsp_timeout", {127'd0, rsp_timeout}, {127'd0, er[128]});
          if (rsp_ready) begin
            $display("rsp data=%h err=%0b timeout=%0b", rsp_data, rsp_err, rsp_timeout);
            void'(rsp_q.pop_front());
            post_rsp = 1;
          end
        end
      end
    end
  end

  task automatic issue_req(input logic [31:0] cmd, input logic [127:0] d);
    int n = 0;
    tx_q.push_back({1'b0, cmd});
    for (int i = 0; i < 4; i++) tx_q.push_back({(i == 3), d[127-32*i -: 32]});
    req_valid = 1'b1; req_cmd = cmd; req_data = d;
    @(negedge axis_aclk);
    while (!req_ready && n < 100) begin @(negedge axis_aclk); n++; end
    if (n >= 100) bound_fail("req_handshake");
    @(posedge axis_aclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic rx_beat(input logic [31:0] d, input logic l);
    int n = 0;
    s00_axis_tvalid = 1'b1; s00_axis_tdata = d; s00_axis_tlast = l;
    @(negedge axis_aclk);
    while (!s00_axis_tready && n < 200) begin @(negedge axis_aclk); n++; end
    if (n >= 200) bound_fail("rx_beat_accept");
    @(posedge axis_aclk); #1;
    s00_axis_tvalid = 1'b0; s00_axis_tlast = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((tx_q.size() != 0 || rsp_q.size() != 0) && n < 2000) begin
      @(posedge axis_aclk); n++;
    end
    #1;
    if (n >= 2000) bound_fail("scoreboard_drain");
  endtask

  initial begin
    logic [127:0] d;
    // Reset state
    #2;
    chk("rst_tvalid", {127'd0, m00_axis_tvalid}, 128'd0);
    chk("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    repeat (2) @(posedge axis_aclk);
    #3 axis_aresetn = 1'b1;
    @(posedge axis_aclk); #1;
    @(posedge axis_aclk); #1;
    chk("post_rst_req_ready", {127'd0, req_ready}, 128'd1);
    chk("post_rst_s_tready", {127'd0, s00_axis_tready}, 128'd0);

    // Test 1: asynchronous reset while beat 2 is stalled
    d = 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff;
    m00_axis_tready = 1'b0;
    issue_req(CMD_ENCRYPT, d);
    m00_axis_tready = 1'b1;
    @(posedge axis_aclk); #1;
    @(posedge axis_aclk); #1;
    m00_axis_tready = 1'b0;
    chk("beat2_before_reset", {96'd0, m00_axis_tdata}, {96'd0, d[95:64]});
    #2 axis_aresetn = 1'b0;
    #1;
    tx_q.delete();
    chk("arst_tvalid", {127'd0, m00_axis_tvalid}, 128'd0);
    chk("arst_tdata", {96'd0, m00_axis_tdata}, 128'd0);
    chk("arst_tlast", {127'd0, m00_axis_tlast}, 128'd0);
    chk("arst_s_tready", {127'd0, s00_axis_tready}, 128'd0);
    chk("arst_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_data[124:0]}, 128'd0);
    repeat (2) @(posedge axis_aclk);
    #3 axis_aresetn = 1'b1;
    m00_axis_tready = 1'b1;
    @(posedge axis_aclk); #1;
    @(posedge axis_aclk); #1;
    chk("arst_release_req_ready", {127'd0, req_ready}, 128'd1);

    // Test 2: SET_KEY, back-to-back beats starting one cycle after the request
    consec_check = 1;
    issue_req(CMD_SET_KEY, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    rsp_q.push_back({1'b0, 1'b0, 128'h11111111_22222222_33333333_44444444});
    rx_beat(32'h11111111, 1'b0); rx_beat(32'h22222222, 1'b0);
    rx_beat(32'h33333333, 1'b0); rx_beat(32'h44444444, 1'b1);
    wait_done();
    consec_check = 0;

    // Test 3: ENCRYPT with toggling tready, FIPS-197 reference ciphertext as reply
    toggle_en = 1;
    issue_req(CMD_ENCRYPT, 128'h3243f6a8_885a308d_313198a2_e0370734);
    rsp_q.push_back({1'b0, 1'b0, 128'h3925841d_02dc09fb_dc118597_196a0b32});
    rx_beat(32'h3925841d, 1'b0); rx_beat(32'h02dc09fb, 1'b0);
    rx_beat(32'hdc118597, 1'b0); rx_beat(32'h196a0b32, 1'b1);
    wait_done();
    toggle_en = 0;
    m00_axis_tready = 1'b1;

    // Test 4a: early tlast on beat 1
    issue_req(CMD_ENCRYPT, 128'h1);
    rsp_q.push_back({1'b1, 1'b0, 128'haaaaaaaa_bbbbbbbb_00000000_00000000});
    rx_beat(32'haaaaaaaa, 1'b0); rx_beat(32'hbbbbbbbb, 1'b1);
    wait_done();

    // Test 4b: four beats, no tlast
    issue_req(CMD_ENCRYPT, 128'h2);
    rsp_q.push_back({1'b1, 1'b0, 128'h01020304_05060708_090a0b0c_0d0e0f10});
    rx_beat(32'h01020304, 1'b0); rx_beat(32'h05060708, 1'b0);
    rx_beat(32'h090a0b0c, 1'b0); rx_beat(32'h0d0e0f10, 1'b0);
    wait_done();

    // Test 5: response back-pressure for 10 cycles
    rsp_ready = 1'b0;
    issue_req(CMD_ENCRYPT, 128'hdeadbeef_cafef00d_01234567_89abcdef);
    rsp_q.push_back({1'b0, 1'b0, 128'hfeedface_0badf00d_13572468_97531864});
    rx_beat(32'hfeedface, 1'b0); rx_beat(32'h0badf00d, 1'b0);
    rx_beat(32'h13572468, 1'b0); rx_beat(32'h97531864, 1'b1);
    repeat (10) @(posedge axis_aclk);
    #1;
    chk("rsp_held_valid", {127'd0, rsp_valid}, 128'd1);
    rsp_ready = 1'b1;
    wait_done();

    // Test 6: no reply
    issue_req(CMD_ENCRYPT, 128'h5);
`ifdef AES_AXIS_CMD_TIMEOUT_EN
    rsp_q.push_back({1'b1, 1'b1, 128'd0});
    wait_done();
`else
    repeat (1000) @(posedge axis_aclk);
    #1;
    chk("no_timeout_rsp_valid", {127'd0, rsp_valid}, 128'd0);
    chk("no_timeout_still_recv", {127'd0, s00_axis_tready}, 128'd1);
    rsp_q.push_back({1'b0, 1'b0, 128'h9});
    rx_beat(32'h0, 1'b0); rx_beat(32'h0, 1'b0);
    rx_beat(32'h0, 1'b0); rx_beat(32'h9, 1'b1);
    wait_done();
`endif

    repeat (3) @(posedge axis_aclk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

endmodule
